// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (IFU fetch / LSU load-store) arbiter onto a single
// memory command port. One transaction in flight, round-robin on contention,
// per-transaction timeout that completes the owner with an error.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [2:0]  lsu_funct3,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } cmd_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
  // Timeout decision is taken one cycle early so the registered error pulse
  // lands exactly TIMEOUT cycles after the grant.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 2);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  cmd_t        cmd_q, cmd_d;
  logic        mem_req_q, mem_req_d;
  logic        ifu_rvalid_q, ifu_rvalid_d, ifu_err_q, ifu_err_d;
  logic        lsu_rvalid_q, lsu_rvalid_d, lsu_err_q, lsu_err_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

  logic grant_any, win_lsu, done, tmo_hit, cpl, cpl_err;
  logic [31:0] cpl_data;

  // Combinational arbitration: gnt pulses in the same IDLE cycle as the request
  always_comb begin
    grant_any = rst_n && (state_q == IDLE) && (ifu_req || lsu_req);
    win_lsu   = lsu_req && (!ifu_req || (last_owner_q == OWN_IFU));
    ifu_gnt   = grant_any && !win_lsu;
    lsu_gnt   = grant_any && win_lsu;
  end

  // Next-state logic for the FSM, command register, timeout and completions
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cmd_d        = cmd_q;
    mem_req_d    = mem_req_q;
    ifu_rvalid_d = 1'b0;
    ifu_err_d    = 1'b0;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rvalid_d = 1'b0;
    lsu_err_d    = 1'b0;
    lsu_rdata_d  = lsu_rdata_q;
    // mem_rvalid only counts once the command has been accepted
    done         = (state_q == WAIT || (state_q == REQ && mem_gnt)) && mem_rvalid;
    tmo_hit      = (state_q != IDLE) && (cnt_q == TMO_LAST);
    cpl          = 1'b0;
    cpl_err      = 1'b0;
    cpl_data     = 32'h0;

    case (state_q)
      IDLE: begin
        cnt_d = 16'h0;
        if (grant_any) begin
          owner_d      = win_lsu;
          last_owner_d = win_lsu;
          cmd_d        = win_lsu ? '{lsu_we, lsu_addr, lsu_wdata, lsu_funct3}
                                 : '{1'b0, ifu_addr, 32'h0, 3'b010};
          mem_req_d    = 1'b1;
          state_d      = REQ;
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (done) begin
          cpl      = 1'b1;
          cpl_data = cmd_q.we ? 32'h0 : mem_rdata;
        end else if (tmo_hit) begin
          cpl     = 1'b1;
          cpl_err = 1'b1;
        end else if (state_q == REQ && mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cpl) begin
      mem_req_d = 1'b0;
      state_d   = IDLE;
      if (owner_q == OWN_LSU) begin
        lsu_rvalid_d = 1'b1;
        lsu_err_d    = cpl_err;
        lsu_rdata_d  = cpl_data;
      end else begin
        ifu_rvalid_d = 1'b1;
        ifu_err_d    = cpl_err;
        ifu_rdata_d  = cpl_data;
      end
    end
  end

  // State and registered outputs; synchronous reset abandons any transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 16'h0;
      owner_q      <= OWN_IFU;
      last_owner_q <= OWN_IFU;
      cmd_q        <= '0;
      mem_req_q    <= 1'b0;
      ifu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      ifu_rdata_q  <= 32'h0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cmd_q        <= cmd_d;
      mem_req_q    <= mem_req_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      ifu_err_q    <= ifu_err_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_err_q    <= lsu_err_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = cmd_q.we;
  assign mem_addr   = cmd_q.addr;
  assign mem_wdata  = cmd_q.wdata;
  assign mem_funct3 = cmd_q.funct3;
  assign ifu_rvalid = ifu_rvalid_q;
  assign ifu_err    = ifu_err_q;
  assign ifu_rdata  = ifu_rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_err    = lsu_err_q;
  assign lsu_rdata  = lsu_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, fetch/store paths,
// reset abandonment, and timeout (on a second instance with TIMEOUT=4).
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        lsu_req, lsu_we;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [2:0]  lsu_funct3;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        ifu_gnt, ifu_rvalid, ifu_err, lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_we, busy;
  logic [2:0]  mem_funct3;

  logic        t_ifu_gnt, t_ifu_rvalid, t_ifu_err, t_lsu_gnt, t_lsu_rvalid, t_lsu_err;
  logic [31:0] t_ifu_rdata, t_lsu_rdata, t_mem_addr, t_mem_wdata;
  logic        t_mem_req, t_mem_we, t_busy;
  logic [2:0]  t_mem_funct3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_funct3(lsu_funct3), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(t_ifu_gnt),
    .ifu_rvalid(t_ifu_rvalid), .ifu_rdata(t_ifu_rdata), .ifu_err(t_ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_funct3(lsu_funct3), .lsu_gnt(t_lsu_gnt),
    .lsu_rvalid(t_lsu_rvalid), .lsu_rdata(t_lsu_rdata), .lsu_err(t_lsu_err),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_funct3(t_mem_funct3), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(t_busy)
  );

  // advance to the next cycle; inputs then change 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req = 0; ifu_addr = 0; lsu_req = 0; lsu_we = 0; lsu_addr = 0;
    lsu_wdata = 0; lsu_funct3 = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    apply_reset();
    ifu_req = 1; lsu_req = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    cyc(); #1;
    checks++; if (ifu_gnt !== 1'b0 || lsu_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b expected 00", ifu_gnt, lsu_gnt); end
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mem_req_busy: got %b%b expected 00", mem_req, busy); end
    checks++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || ifu_err !== 1'b0 || lsu_err !== 1'b0) begin errors++; $display("FAIL reset_rvalid_err: got %b%b%b%b expected 0000", ifu_rvalid, lsu_rvalid, ifu_err, lsu_err); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0 || mem_we !== 1'b0 || mem_funct3 !== 3'b0) begin errors++; $display("FAIL reset_data: addr %h wdata %h ird %h lrd %h expected all 0", mem_addr, mem_wdata, ifu_rdata, lsu_rdata); end
    idle_inputs();
  endtask

  // both request right after reset, zero-latency memory
  task automatic test_first_arb();
    apply_reset();
    rst_n = 1; ifu_req = 1; ifu_addr = 32'h0000_1000;
    lsu_req = 1; lsu_addr = 32'h0000_2000; lsu_funct3 = 3'b001;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    #1; // cycle 0
    checks++; if (lsu_gnt !== 1'b1 || ifu_gnt !== 1'b0) begin errors++; $display("FAIL first_arb_c0: lsu_gnt %b ifu_gnt %b expected 1 0", lsu_gnt, ifu_gnt); end
    cyc(); lsu_req = 0; #1; // cycle 1
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_funct3 !== 3'b001 || busy !== 1'b1) begin errors++; $display("FAIL first_arb_c1: mem_req %b addr %h f3 %b busy %b expected 1 00002000 001 1", mem_req, mem_addr, mem_funct3, busy); end
    checks++; if (ifu_gnt !== 1'b0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL first_arb_c1_ifu: gnt %b rvalid %b expected 0 0", ifu_gnt, ifu_rvalid); end
    cyc(); #1; // cycle 2
    checks++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h1234_5678 || lsu_err !== 1'b0) begin errors++; $display("FAIL first_arb_c2_lsu: rvalid %b rdata %h err %b expected 1 12345678 0", lsu_rvalid, lsu_rdata, lsu_err); end
    checks++; if (ifu_gnt !== 1'b1 || mem_req !== 1'b0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL first_arb_c2_ifu: gnt %b mem_req %b rvalid %b expected 1 0 0", ifu_gnt, mem_req, ifu_rvalid); end
    cyc(); ifu_req = 0; mem_rdata = 32'hCAFE_0001; #1; // cycle 3
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_funct3 !== 3'b010 || mem_we !== 1'b0 || lsu_rvalid !== 1'b0) begin errors++; $display("FAIL first_arb_c3: mem_req %b addr %h f3 %b we %b lrv %b expected 1 00001000 010 0 0", mem_req, mem_addr, mem_funct3, mem_we, lsu_rvalid); end
    cyc(); #1; // cycle 4
    checks++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'hCAFE_0001 || lsu_rvalid !== 1'b0) begin errors++; $display("FAIL first_arb_c4: ifu_rvalid %b rdata %h lsu_rvalid %b expected 1 cafe0001 0", ifu_rvalid, ifu_rdata, lsu_rvalid); end
    cyc(); #1; // cycle 5: mem_rvalid still high in IDLE must not complete anything
    checks++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_rvalid_ignored: ifu %b lsu %b busy %b expected 0 0 0", ifu_rvalid, lsu_rvalid, busy); end
    idle_inputs();
  endtask

  // fetch with delayed gnt/rvalid, then a store queued during WAIT
  task automatic test_fetch_then_store();
    cyc();
    ifu_req = 1; ifu_addr = 32'h8000_0000; #1; // cycle 0
    checks++; if (ifu_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %b expected 1", ifu_gnt); end
    cyc(); ifu_req = 0; #1; // cycle 1
    cyc(); mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0; #1; // cycle 2: rvalid without gnt
    cyc(); mem_rvalid = 0; mem_gnt = 1; #1; // cycle 3
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_c3: mem_req %b addr %h rvalid %b expected 1 80000000 0", mem_req, mem_addr, ifu_rvalid); end
    cyc(); mem_gnt = 0;
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_funct3 = 3'b010; #1; // cycle 4
    checks++; if (mem_req !== 1'b0 || busy !== 1'b1 || lsu_gnt !== 1'b0) begin errors++; $display("FAIL fetch_wait_c4: mem_req %b busy %b lsu_gnt %b expected 0 1 0", mem_req, busy, lsu_gnt); end
    cyc(); #1; // cycle 5
    cyc(); mem_rvalid = 1; mem_rdata = 32'h0000_0297; #1; // cycle 6
    checks++; if (ifu_rvalid !== 1'b0 || lsu_gnt !== 1'b0) begin errors++; $display("FAIL fetch_c6: rvalid %b lsu_gnt %b expected 0 0", ifu_rvalid, lsu_gnt); end
    cyc(); mem_rvalid = 0; mem_rdata = 0; #1; // cycle 7
    checks++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0297 || ifu_err !== 1'b0) begin errors++; $display("FAIL fetch_cpl: rvalid %b rdata %h err %b expected 1 00000297 0", ifu_rvalid, ifu_rdata, ifu_err); end
    checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt_same_cycle: got %b expected 1", lsu_gnt); end
    cyc(); lsu_req = 0; lsu_we = 0; lsu_wdata = 0; #1; // cycle 8
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h8000_1000 || mem_funct3 !== 3'b010) begin errors++; $display("FAIL store_cmd: req %b we %b wdata %h addr %h f3 %b expected 1 1 deadbeef 80001000 010", mem_req, mem_we, mem_wdata, mem_addr, mem_funct3); end
    checks++; if (ifu_rvalid !== 1'b0 || ifu_rdata !== 32'h0000_0297) begin errors++; $display("FAIL ifu_rdata_hold: rvalid %b rdata %h expected 0 00000297", ifu_rvalid, ifu_rdata); end
    cyc(); #1; // cycle 9
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_hold: req %b we %b wdata %h expected 1 1 deadbeef", mem_req, mem_we, mem_wdata); end
    cyc(); mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF; #1; // cycle 10
    cyc(); idle_inputs(); #1; // cycle 11
    checks++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h0 || lsu_err !== 1'b0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL store_cpl: rvalid %b rdata %h err %b ifu_rvalid %b expected 1 0 0 0", lsu_rvalid, lsu_rdata, lsu_err, ifu_rvalid); end
  endtask

  // both requesters held high: grants must alternate LSU, IFU, LSU, IFU
  task automatic test_back_to_back();
    logic exp_l, exp_i;
    apply_reset();
    rst_n = 1; ifu_req = 1; lsu_req = 1; mem_gnt = 1; mem_rvalid = 1;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_l = (i % 4 == 0);
      exp_i = (i % 4 == 2);
      checks++; if (lsu_gnt !== exp_l || ifu_gnt !== exp_i) begin errors++; $display("FAIL alternate_c%0d: lsu_gnt %b ifu_gnt %b expected %b %b", i, lsu_gnt, ifu_gnt, exp_l, exp_i); end
      cyc(); #1;
    end
    idle_inputs();
  endtask

  // reset while waiting on memory, late response must be dropped
  task automatic test_reset_mid();
    cyc(); cyc(); cyc();
    ifu_req = 1; ifu_addr = 32'h0000_4000; mem_gnt = 1; #1; // cycle 0
    checks++; if (ifu_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 1", ifu_gnt); end
    cyc(); ifu_req = 0; #1; // cycle 1: accepted
    cyc(); mem_gnt = 0; rst_n = 0; #1; // cycle 2: in WAIT
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_wait: busy %b expected 1", busy); end
    cyc(); rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA; #1; // cycle 3
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: busy %b mem_req %b expected 0 0", busy, mem_req); end
    cyc(); mem_rvalid = 0; #1; // cycle 4
    checks++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_drop: ifu %b lsu %b busy %b expected 0 0 0", ifu_rvalid, lsu_rvalid, busy); end
    lsu_req = 1; lsu_addr = 32'h0000_5000; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D; #1;
    checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_next_gnt: got %b expected 1", lsu_gnt); end
    cyc(); lsu_req = 0; #1; // cycle 5
    cyc(); #1; // cycle 6
    checks++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h0BAD_F00D || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_next_cpl: rvalid %b rdata %h ifu %b expected 1 0badf00d 0", lsu_rvalid, lsu_rdata, ifu_rvalid); end
    idle_inputs();
  endtask

  // TIMEOUT=4 instance: error completion 4 cycles after grant
  task automatic test_timeout();
    apply_reset();
    rst_n = 1; ifu_req = 1; ifu_addr = 32'h8000_0040; mem_gnt = 1; #1; // cycle 0
    checks++; if (t_ifu_gnt !== 1'b1) begin errors++; $display("FAIL tmo_gnt: got %b expected 1", t_ifu_gnt); end
    cyc(); ifu_req = 0; #1; // cycle 1
    for (int c = 1; c < 4; c++) begin
      checks++; if (t_ifu_rvalid !== 1'b0 || t_busy !== 1'b1) begin errors++; $display("FAIL tmo_early_c%0d: rvalid %b busy %b expected 0 1", c, t_ifu_rvalid, t_busy); end
      cyc(); #1;
    end
    // cycle 4
    checks++; if (t_ifu_rvalid !== 1'b1 || t_ifu_err !== 1'b1 || t_ifu_rdata !== 32'h0 || t_lsu_rvalid !== 1'b0) begin errors++; $display("FAIL tmo_cpl: rvalid %b err %b rdata %h lsu_rvalid %b expected 1 1 0 0", t_ifu_rvalid, t_ifu_err, t_ifu_rdata, t_lsu_rvalid); end
    checks++; if (t_mem_req !== 1'b0 || t_busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: mem_req %b busy %b expected 0 0", t_mem_req, t_busy); end
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    cyc(); mem_rvalid = 0; #1; // cycle 5
    checks++; if (t_ifu_rvalid !== 1'b0 || t_ifu_err !== 1'b0 || t_lsu_rvalid !== 1'b0) begin errors++; $display("FAIL tmo_late_rvalid: ifu %b err %b lsu %b expected 0 0 0", t_ifu_rvalid, t_ifu_err, t_lsu_rvalid); end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_first_arb();
    test_fetch_then_store();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, 255, max cycles from mem_req assertion to mem_rvalid before error completion; range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ifu_req  input  1  fetch request; held with ifu_addr until ifu_gnt.
REQ-005 ifu_addr  input  32  fetch address; always a 32-bit read (funct3 3'b010).
REQ-006 ifu_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 ifu_rvalid / ifu_rdata / ifu_err  output  1/32/1  fetch completion pulse, data, error flag.
REQ-008 lsu_req / lsu_we / lsu_addr / lsu_wdata / lsu_funct3  input  1/1/32/32/3  load/store request; all held until lsu_gnt.
REQ-009 lsu_gnt  output  1  one-cycle pulse: LSU request accepted.
REQ-010 lsu_rvalid / lsu_rdata / lsu_err  output  1/32/1  completion pulse for loads and stores; rdata 0 for stores.
REQ-011 mem_req / mem_we / mem_addr / mem_wdata / mem_funct3  output  1/1/32/32/3  shared memory command port.
REQ-012 mem_gnt  input  1  memory accepts command this cycle.
REQ-013 mem_rvalid / mem_rdata  input  1/32  memory response pulse and data.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States: IDLE, REQ (driving mem_req), WAIT (awaiting mem_rvalid); one transaction outstanding at most.
REQ-016 In IDLE with any request: winner selected combinationally, its gnt pulsed that cycle, command registered, next state REQ.
REQ-017 Single requester wins directly; both requesting -> winner is the one not recorded in last_owner; last_owner updates to the winner on each grant.
REQ-018 Loser's gnt stays 0; it is served on the next IDLE cycle without additional arbitration delay.
REQ-019 In REQ: mem_req=1 with registered command; mem_* command signals stable until mem_gnt.
REQ-020 REQ with mem_gnt=1, mem_rvalid=0 -> WAIT, mem_req drops next cycle.
REQ-021 REQ with mem_gnt=1 and mem_rvalid=1 same cycle -> complete immediately (zero-latency memory).
REQ-022 Completion: owner's rvalid pulses exactly one cycle, the cycle after mem_rvalid sampled; rdata registered from mem_rdata; err=0; next state IDLE.
REQ-023 New grant allowed in the same cycle the previous rvalid pulse is presented.
REQ-024 mem_rvalid ignored in IDLE and in REQ without mem_gnt; never routed to a non-owner.
REQ-025 Timeout counter clears on grant, increments each cycle in REQ/WAIT; on reaching TIMEOUT without completion: owner rvalid=1, err=1, rdata=0, mem_req=0, -> IDLE.
REQ-026 A mem_rvalid arriving after timeout is discarded.
REQ-027 Non-owner rvalid/err always 0; rdata outputs hold last value between pulses.
REQ-028 Requests sampled in REQ/WAIT are not granted and not lost; requester keeps req high.

Reset
REQ-029 rst_n=0 at posedge: state IDLE, counter 0, last_owner=IFU, all outputs 0 (gnt, rvalid, err, rdata, mem_*, busy).
REQ-030 Reset mid-transaction abandons it: no rvalid for that transaction, later mem_rvalid ignored.
REQ-031 First simultaneous request after reset is granted to LSU.

Verification
REQ-032 Both req in IDLE after reset, mem_gnt=mem_rvalid=1 -> lsu_gnt cycle 0, mem_req cycle 1, lsu_rvalid cycle 2; ifu_gnt cycle 2, ifu_rvalid cycle 4.
REQ-033 ifu_req addr 0x80000000, mem_gnt cycle 3, mem_rvalid cycle 6 data 0x00000297 -> ifu_rvalid=1 cycle 7, ifu_rdata=0x00000297, ifu_err=0.
REQ-034 LSU store we=1 addr 0x80001000 wdata 0xDEADBEEF funct3 010 -> mem_we=1, mem_wdata=0xDEADBEEF held until mem_gnt; lsu_rvalid pulse, lsu_rdata=0.
REQ-035 TIMEOUT=4, mem_gnt=1, mem_rvalid never -> ifu_rvalid=1, ifu_err=1 exactly 4 cycles after grant; late mem_rvalid produces no pulse.
REQ-036 rst_n low during WAIT, then mem_rvalid -> no rvalid on either port, busy=0, next request served normally.
REQ-037 Continuous both-req stream -> grants strictly alternate LSU, IFU, LSU, IFU.
